// File: rtl/axil_reg_if_wr.sv
// AXI4-lite write channel to single-cycle register-strobe adapter.
// AW and W are each held in a one-entry buffer. A write issues from IDLE once
// both buffers are full. A missing acknowledge turns into SLVERR after TIMEOUT
// cycles.
// Optional build macro AXIL_REG_IF_WR_ADDR_CHECK_EN: addresses outside
// [ADDR_BASE, ADDR_BASE+ADDR_SIZE) are answered with DECERR and never strobe
// the register file.
module axil_reg_if_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int TIMEOUT    = 16
`ifdef AXIL_REG_IF_WR_ADDR_CHECK_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_WIDTH:0]   ADDR_SIZE = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic [2:0]            reg_wr_prot,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ack
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  localparam logic [15:0] TO_CNT = TIMEOUT[15:0];

  state_t                state_q, state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]            aw_prot_q, aw_prot_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  in_range;

`ifdef AXIL_REG_IF_WR_ADDR_CHECK_EN
  logic [ADDR_WIDTH:0] addr_ext, base_ext;
  // Range check done one bit wider so BASE+SIZE cannot wrap.
  always_comb begin
    addr_ext = {1'b0, aw_addr_q};
    base_ext = {1'b0, ADDR_BASE};
    in_range = (addr_ext >= base_ext) && (addr_ext < base_ext + ADDR_SIZE);
  end
`else
  assign in_range = 1'b1;
`endif

  // Next-state: hold-buffer capture, issue, ack/timeout and B handshake.
  always_comb begin
    state_d   = state_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    en_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    cnt_d     = cnt_q;

    // Ready is low whenever a buffer is full, so capture never races a clear.
    if (s_axil_awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil_awaddr;
      aw_prot_d = s_axil_awprot;
    end
    if (s_axil_wvalid && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end

    case (state_q)
      IDLE: begin
        if (aw_full_q && w_full_q) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          if (in_range) begin
            en_d    = 1'b1;
            addr_d  = aw_addr_q;
            data_d  = w_data_q;
            strb_d  = w_strb_q;
            prot_d  = aw_prot_q;
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            bvalid_d = 1'b1;
            bresp_d  = 2'b11;
            state_d  = RESP;
          end
        end
      end
      WRITE: begin
        // Ack takes priority over a same-cycle expiry.
        if (reg_wr_ack) begin
          bvalid_d = 1'b1;
          bresp_d  = 2'b00;
          state_d  = RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_CNT) begin
          bvalid_d = 1'b1;
          bresp_d  = 2'b10;
          state_d  = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (s_axil_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
  end

  // All state and registered outputs; reset abandons any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign reg_wr_en      = en_q;
  assign reg_wr_addr    = addr_q;
  assign reg_wr_data    = data_q;
  assign reg_wr_strb    = strb_q;
  assign reg_wr_prot    = prot_q;

endmodule

// File: tb/tb_axil_reg_if_wr.sv
// Directed bench for axil_reg_if_wr: latency, ordering, timeout, backpressure,
// reset mid-write and, when the address-check macro is defined, DECERR.
module tb_axil_reg_if_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_strb;
  logic [2:0]  r_prot;
  logic        r_en;
  logic        r_ack = 1'b0;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

`ifdef AXIL_REG_IF_WR_ADDR_CHECK_EN
  axil_reg_if_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16),
                   .ADDR_BASE(32'h1000), .ADDR_SIZE(33'h100)) dut (
`else
  axil_reg_if_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .reg_wr_addr(r_addr), .reg_wr_data(r_data), .reg_wr_strb(r_strb),
    .reg_wr_prot(r_prot), .reg_wr_en(r_en), .reg_wr_ack(r_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present AW and W together for one cycle (cycle N); returns in N+1.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awprot = 3'b010; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_en", r_en, 0);
    chk("rst_addr", r_addr, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);

    // Same-cycle AW/W, ack tied high
    r_ack = 1'b1;
    send_pair(32'h10, 32'hDEADBEEF, 4'hF);          // now N+1
    chk("t1_awready_drop", awready, 0);
    chk("t1_wready_drop", wready, 0);
    chk("t1_en_n1", r_en, 0);
    tick();                                          // N+2
    chk("t1_en", r_en, 1);
    chk("t1_addr", r_addr, 32'h10);
    chk("t1_data", r_data, 32'hDEADBEEF);
    chk("t1_strb", r_strb, 4'hF);
    chk("t1_prot", r_prot, 3'b010);
    chk("t1_awready_back", awready, 1);
    chk("t1_bvalid_n2", bvalid, 0);
    tick();                                          // N+3
    chk("t1_en_off", r_en, 0);
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 2'b00);
    bready = 1'b1;
    tick();
    chk("t1_bvalid_drop", bvalid, 0);

    // W five cycles ahead of AW
    wdata = 32'h55AA; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_wready_held", wready, 0);
    tick(); tick(); tick(); tick();
    chk("t2_wready_still", wready, 0);
    chk("t2_no_en", r_en, 0);
    chk("t2_awready", awready, 1);
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    chk("t2_en", r_en, 1);
    chk("t2_addr", r_addr, 32'h20);
    chk("t2_data", r_data, 32'h55AA);
    chk("t2_strb", r_strb, 4'h3);
    tick();
    chk("t2_bvalid", bvalid, 1);
    chk("t2_bresp", bresp, 2'b00);
    tick();

    // Timeout: no ack
    r_ack = 1'b0;
    send_pair(32'h24, 32'h0BAD0BAD, 4'hF);
    tick();                                          // E
    chk("t3_en", r_en, 1);
    for (int i = 0; i < 16; i++) tick();             // E+16
    chk("t3_no_bvalid_e16", bvalid, 0);
    tick();                                          // E+17
    chk("t3_bvalid", bvalid, 1);
    chk("t3_bresp", bresp, 2'b10);
    tick();
    chk("t3_bvalid_drop", bvalid, 0);
    r_ack = 1'b1;
    tick();
    r_ack = 1'b0;
    tick();
    chk("t3_idle_ack_bvalid", bvalid, 0);
    chk("t3_idle_ack_en", r_en, 0);

    // Backpressure on B while a second write arrives
    r_ack = 1'b1;
    bready = 1'b0;
    send_pair(32'h30, 32'h11111111, 4'hF);
    tick(); tick();                                  // N+3, bvalid held
    chk("t4_bvalid_a", bvalid, 1);
    send_pair(32'h34, 32'h22222222, 4'hC);
    chk("t4_awready_full", awready, 0);
    chk("t4_wready_full", wready, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("t4_bvalid_hold", bvalid, 1);
    chk("t4_bresp_hold", bresp, 2'b00);
    chk("t4_no_en", r_en, 0);
    chk("t4_addr_first", r_addr, 32'h30);
    bready = 1'b1;
    tick();                                          // X+1
    chk("t4_bvalid_drop", bvalid, 0);
    chk("t4_no_same_cycle_issue", r_en, 0);
    tick();                                          // X+2
    chk("t4_en2", r_en, 1);
    chk("t4_addr2", r_addr, 32'h34);
    chk("t4_data2", r_data, 32'h22222222);
    chk("t4_strb2", r_strb, 4'hC);
    tick();
    chk("t4_bvalid2", bvalid, 1);
    tick();

    // Reset in the cycle after reg_wr_en
    r_ack = 1'b0;
    send_pair(32'h40, 32'hCAFE, 4'hF);
    tick();
    chk("t5_en", r_en, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_addr", r_addr, 0);
    chk("t5_rst_data", r_data, 0);
    chk("t5_rst_awready", awready, 0);
    chk("t5_rst_bvalid", bvalid, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t5_awready", awready, 1);
    chk("t5_wready", wready, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("t5_no_stale_bvalid", bvalid, 0);
    chk("t5_no_stale_en", r_en, 0);

`ifdef AXIL_REG_IF_WR_ADDR_CHECK_EN
    // Out-of-range -> DECERR in N+2, in-range -> normal
    r_ack = 1'b1;
    send_pair(32'h1100, 32'h77, 4'hF);
    tick();                                          // N+2
    chk("t6_dec_bvalid", bvalid, 1);
    chk("t6_dec_bresp", bresp, 2'b11);
    chk("t6_dec_no_en", r_en, 0);
    tick();
    send_pair(32'h10FC, 32'h88, 4'hF);
    tick();
    chk("t6_in_en", r_en, 1);
    chk("t6_in_addr", r_addr, 32'h10FC);
    tick();
    chk("t6_in_bresp", bresp, 2'b00);
    chk("t6_in_bvalid", bvalid, 1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
